mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage pipeline.
- Grants one requester at a time, holds the memory request until the memory completes it, and registers the read data.
- Returns per-requester stall signals that the hazard unit ORs into the pipeline stall and flush controls.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_pick.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, GNT_I, GNT_D)
//   REQ_I/REQ_D : requester ids, used as bit positions in the request and
//                 grant vectors and as the value held in the round-robin
//                 history register
//   req_vec_t   : two-bit request/grant vector indexed by the requester ids
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef logic [1:0] req_vec_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick
// Combinational grant selection between the fetch and data requesters.
// Build option: define ARB_RR_EN for round-robin arbitration on contention;
// without it data always beats instruction fetch.
// Ports:
//   reqMasked_i : pending requests, already masked by the done pulses
//   rrLast_i    : requester id granted most recently (round-robin only)
//   grant_o     : one-hot grant, all zero when nothing is pending
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  req_vec_t reqMasked_i,
  input  logic     rrLast_i,
  output req_vec_t grant_o
);

`ifdef ARB_RR_EN
  // On contention hand the port to whoever did not have it last; a lone
  // request is granted straight away.
  always_comb begin
    grant_o = '0;
    if (reqMasked_i[REQ_D] && reqMasked_i[REQ_I]) begin
      if (rrLast_i == REQ_D) begin
        grant_o[REQ_I] = 1'b1;
      end else begin
        grant_o[REQ_D] = 1'b1;
      end
    end else if (reqMasked_i[REQ_D]) begin
      grant_o[REQ_D] = 1'b1;
    end else if (reqMasked_i[REQ_I]) begin
      grant_o[REQ_I] = 1'b1;
    end
  end
`else
  // The history input is meaningless with fixed priority.
  logic unusedRrLast;
  assign unusedRrLast = rrLast_i;

  // Fixed priority: the MEM stage is further down the pipe, so serving it
  // first frees the older instruction first.
  always_comb begin
    grant_o = '0;
    if (reqMasked_i[REQ_D]) begin
      grant_o[REQ_D] = 1'b1;
    end else if (reqMasked_i[REQ_I]) begin
      grant_o[REQ_I] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between IF-stage fetch and MEM-stage
// load/store. One requester is granted at a time; the memory request is
// registered and held until the memory pulses mready, and the read data is
// captured into per-requester result registers with a one-cycle done pulse.
// Build option: ARB_RR_EN selects round-robin arbitration (see arb_pick).
// Ports:
//   clk_i, rst_i          : clock, synchronous active-low reset
//   ireq_i, iaddr_i       : fetch request and address
//   irdata_o, istall_o    : fetched word (valid on idone), fetch stall
//   dreq_i, dwe_i         : data request, 1=store 0=load
//   daddr_i, dwdata_i     : data address and store data
//   drdata_o, dstall_o    : load data (valid on ddone), data stall
//   mreq_o, mwe_o         : memory request and write enable (registered)
//   maddr_o, mwdata_o     : memory address and write data (registered)
//   mrdata_i, mready_i    : memory read data and one-cycle completion pulse
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ireq_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic [DATA_W-1:0] irdata_o,
  output logic              istall_o,
  input  logic              dreq_i,
  input  logic              dwe_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [DATA_W-1:0] dwdata_i,
  output logic [DATA_W-1:0] drdata_o,
  output logic              dstall_o,
  output logic              mreq_o,
  output logic              mwe_o,
  output logic [ADDR_W-1:0] maddr_o,
  output logic [DATA_W-1:0] mwdata_o,
  input  logic [DATA_W-1:0] mrdata_i,
  input  logic              mready_i
);

  arb_state_e        state_q,  state_d;
  logic              mreq_q,   mreq_d;
  logic              mwe_q,    mwe_d;
  logic [ADDR_W-1:0] maddr_q,  maddr_d;
  logic [DATA_W-1:0] mwdata_q, mwdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              idone_q,  idone_d;
  logic              ddone_q,  ddone_d;
  logic              rrLast;
  req_vec_t          reqMasked;
  req_vec_t          grant;

  // A requester whose done pulse is showing this cycle still holds its
  // request line; masking it here stops the same access being reissued.
  assign reqMasked[REQ_D] = dreq_i & ~ddone_q;
  assign reqMasked[REQ_I] = ireq_i & ~idone_q;

`ifdef ARB_RR_EN
  logic rrLast_q, rrLast_d;

  // Round-robin history: remembers the last requester granted.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rrLast_q <= REQ_I;
    end else begin
      rrLast_q <= rrLast_d;
    end
  end

  always_comb begin
    rrLast_d = rrLast_q;
    if (state_q == IDLE) begin
      if (grant[REQ_D]) begin
        rrLast_d = REQ_D;
      end else if (grant[REQ_I]) begin
        rrLast_d = REQ_I;
      end
    end
  end

  assign rrLast = rrLast_q;
`else
  assign rrLast = REQ_I;
`endif

  arb_pick uPick (
    .reqMasked_i (reqMasked),
    .rrLast_i    (rrLast),
    .grant_o     (grant)
  );

  // State and all memory-side / result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      idone_q  <= 1'b0;
      ddone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      idone_q  <= idone_d;
      ddone_q  <= ddone_d;
    end
  end

  // Next state: IDLE latches the winner's request into the memory
  // registers; a grant state holds them untouched until mready, then
  // captures the result and raises the matching done pulse. mready seen in
  // IDLE falls through the defaults and is ignored.
  always_comb begin
    state_d  = state_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    idone_d  = 1'b0;
    ddone_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant[REQ_D]) begin
          state_d  = GNT_D;
          mreq_d   = 1'b1;
          mwe_d    = dwe_i;
          maddr_d  = daddr_i;
          mwdata_d = dwdata_i;
        end else if (grant[REQ_I]) begin
          state_d  = GNT_I;
          mreq_d   = 1'b1;
          mwe_d    = 1'b0;
          maddr_d  = iaddr_i;
        end else begin
          mreq_d   = 1'b0;
        end
      end
      GNT_I: begin
        if (mready_i) begin
          state_d  = IDLE;
          mreq_d   = 1'b0;
          mwe_d    = 1'b0;
          irdata_d = mrdata_i;
          idone_d  = 1'b1;
        end
      end
      GNT_D: begin
        if (mready_i) begin
          state_d = IDLE;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          ddone_d = 1'b1;
          if (!mwe_q) begin
            drdata_d = mrdata_i;
          end
        end
      end
      default: begin
        state_d = IDLE;
        mreq_d  = 1'b0;
        mwe_d   = 1'b0;
      end
    endcase
  end

  assign istall_o = ireq_i & ~idone_q;
  assign dstall_o = dreq_i & ~ddone_q;
  assign irdata_o = irdata_q;
  assign drdata_o = drdata_q;
  assign mreq_o   = mreq_q;
  assign mwe_o    = mwe_q;
  assign maddr_o  = maddr_q;
  assign mwdata_o = mwdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: a table of per-cycle vectors for
// the directed corner cases, a hand-written back-to-back contention run, and
// a randomized run against a transaction-level reference model and a
// behavioural memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        istall;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dstall;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic [31:0] mrdata;
  logic        mready;

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ireq_i   (ireq),
    .iaddr_i  (iaddr),
    .irdata_o (irdata),
    .istall_o (istall),
    .dreq_i   (dreq),
    .dwe_i    (dwe),
    .daddr_i  (daddr),
    .dwdata_i (dwdata),
    .drdata_o (drdata),
    .dstall_o (dstall),
    .mreq_o   (mreq),
    .mwe_o    (mwe),
    .maddr_o  (maddr),
    .mwdata_o (mwdata),
    .mrdata_i (mrdata),
    .mready_i (mready)
  );

  // One table row: inputs held for one cycle, outputs expected after the edge.
  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mready;
    logic [31:0] mrdata;
    logic        eMreq;
    logic        eMwe;
    logic [31:0] eMaddr;
    logic [31:0] eMwdata;
    logic        eIdone;
    logic [31:0] eIrdata;
    logic        eDdone;
    logic [31:0] eDrdata;
    logic        eIstall;
    logic        eDstall;
  } vec_t;

  vec_t  vecs[$];
  string vecNames[$];

  task automatic addVec(input string name,
                        input logic r, input logic iq, input logic [31:0] ia,
                        input logic dq, input logic w, input logic [31:0] da,
                        input logic [31:0] dw, input logic rdy, input logic [31:0] rd,
                        input logic eq, input logic ew, input logic [31:0] ea,
                        input logic [31:0] ewd, input logic eid, input logic [31:0] eir,
                        input logic edd, input logic [31:0] edr,
                        input logic eis, input logic eds);
    vec_t v;
    v = '{r, iq, ia, dq, w, da, dw, rdy, rd, eq, ew, ea, ewd, eid, eir, edd, edr, eis, eds};
    vecs.push_back(v);
    vecNames.push_back(name);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst    = v.rst;
    ireq   = v.ireq;
    iaddr  = v.iaddr;
    dreq   = v.dreq;
    dwe    = v.dwe;
    daddr  = v.daddr;
    dwdata = v.dwdata;
    mready = v.mready;
    mrdata = v.mrdata;
  endtask

  task automatic checkVec(input string n, input vec_t v);
    checkOutput({n, ".mreq"},   {31'd0, mreq},   {31'd0, v.eMreq});
    checkOutput({n, ".mwe"},    {31'd0, mwe},    {31'd0, v.eMwe});
    checkOutput({n, ".maddr"},  maddr,           v.eMaddr);
    checkOutput({n, ".mwdata"}, mwdata,          v.eMwdata);
    checkOutput({n, ".idone"},  {31'd0, dut.idone_q}, {31'd0, v.eIdone});
    checkOutput({n, ".irdata"}, irdata,          v.eIrdata);
    checkOutput({n, ".ddone"},  {31'd0, dut.ddone_q}, {31'd0, v.eDdone});
    checkOutput({n, ".drdata"}, drdata,          v.eDrdata);
    checkOutput({n, ".istall"}, {31'd0, istall}, {31'd0, v.eIstall});
    checkOutput({n, ".dstall"}, {31'd0, dstall}, {31'd0, v.eDstall});
  endtask

  // Reference model: who owns the memory, what the memory holds, and the
  // outputs the arbiter should show after the coming edge.
  int          owner;          // 0 none, 1 fetch, 2 data
  logic        eMreq, eMwe, eIdone, eDdone, eRrD;
  logic [31:0] eMaddr, eMwdata, eIrdata, eDrdata;
  logic [31:0] memArr[256];    // memory seen by the DUT
  logic [31:0] modelMem[256];  // memory as the model believes it

  task automatic modelReset();
    owner = 0; eMreq = 0; eMwe = 0; eIdone = 0; eDdone = 0; eRrD = 0;
    eMaddr = '0; eMwdata = '0; eIrdata = '0; eDrdata = '0;
  endtask

  task automatic modelStep();
    logic pendI, pendD, newI, newD;
    int   pick;
    if (!rst) begin
      modelReset();
    end else begin
      newI = 0;
      newD = 0;
      pendI = ireq && !eIdone;
      pendD = dreq && !eDdone;
      if (owner == 1) begin
        if (mready) begin
          eIrdata = modelMem[eMaddr[9:2]];
          newI = 1; owner = 0; eMreq = 0; eMwe = 0;
        end
      end else if (owner == 2) begin
        if (mready) begin
          if (eMwe) modelMem[eMaddr[9:2]] = eMwdata;
          else      eDrdata = modelMem[eMaddr[9:2]];
          newD = 1; owner = 0; eMreq = 0; eMwe = 0;
        end
      end else begin
        pick = 0;
        if (pendI && pendD) begin
`ifdef ARB_RR_EN
          pick = eRrD ? 1 : 2;
`else
          pick = 2;
`endif
        end else if (pendD) begin
          pick = 2;
        end else if (pendI) begin
          pick = 1;
        end
        if (pick == 2) begin
          owner = 2; eMreq = 1; eMwe = dwe; eMaddr = daddr; eMwdata = dwdata; eRrD = 1;
        end else if (pick == 1) begin
          owner = 1; eMreq = 1; eMwe = 0; eMaddr = iaddr; eRrD = 0;
        end else begin
          eMreq = 0;
        end
      end
      eIdone = newI;
      eDdone = newD;
    end
  endtask

  initial begin
    logic [31:0] order[$];
    logic [31:0] expOrder[4];
    logic        prevMreq;
    logic        iFinish, dFinish, memPrev;
    int          memAge, memLat;

    rst = 0; ireq = 0; iaddr = 0; dreq = 0; dwe = 0; daddr = 0; dwdata = 0;
    mready = 0; mrdata = 0;

    // name     rst ireq iaddr  dreq dwe daddr  dwdata  rdy mrdata | mreq mwe maddr mwdata idone irdata ddone drdata istall dstall
    addVec("rst0", 0,0,32'h0,  0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h0,  32'h0, 0,32'h0, 0,32'h0, 0,0);
    addVec("rst1", 0,0,32'h0,  0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h0,  32'h0, 0,32'h0, 0,32'h0, 0,0);
    addVec("con1", 1,1,32'h44, 1,0,32'h80, 32'h0, 0,32'h0,        1,0,32'h80, 32'h0, 0,32'h0, 0,32'h0, 1,1);
    addVec("con2", 1,1,32'h44, 1,0,32'h80, 32'h0, 1,32'hA5,       0,0,32'h80, 32'h0, 0,32'h0, 1,32'hA5, 1,0);
    addVec("con3", 1,1,32'h44, 1,0,32'h80, 32'h0, 0,32'h0,        1,0,32'h44, 32'h0, 0,32'h0, 0,32'hA5, 1,1);
    addVec("con4", 1,1,32'h44, 0,0,32'h0,  32'h0, 1,32'h11111111, 0,0,32'h44, 32'h0, 1,32'h11111111, 0,32'hA5, 0,0);
    addVec("con5", 1,1,32'h44, 0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h44, 32'h0, 0,32'h11111111, 0,32'hA5, 1,0);
    addVec("con6", 1,0,32'h0,  0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h44, 32'h0, 0,32'h11111111, 0,32'hA5, 0,0);
    addVec("ftc1", 1,1,32'h40, 0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h40, 32'h0, 0,32'h11111111, 0,32'hA5, 1,0);
    addVec("ftc2", 1,1,32'h40, 0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h40, 32'h0, 0,32'h11111111, 0,32'hA5, 1,0);
    addVec("ftc3", 1,1,32'h40, 0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h40, 32'h0, 0,32'h11111111, 0,32'hA5, 1,0);
    addVec("ftc4", 1,1,32'h40, 0,0,32'h0,  32'h0, 1,32'h20080005, 0,0,32'h40, 32'h0, 1,32'h20080005, 0,32'hA5, 0,0);
    addVec("ftc5", 1,1,32'h40, 0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h40, 32'h0, 0,32'h20080005, 0,32'hA5, 1,0);
    addVec("ftc6", 1,0,32'h0,  0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h40, 32'h0, 0,32'h20080005, 0,32'hA5, 0,0);
    addVec("sto1", 1,0,32'h0,  1,1,32'h100,32'hDEADBEEF, 0,32'h0, 1,1,32'h100,32'hDEADBEEF, 0,32'h20080005, 0,32'hA5, 0,1);
    addVec("sto2", 1,0,32'h0,  1,1,32'h100,32'hDEADBEEF, 0,32'h0, 1,1,32'h100,32'hDEADBEEF, 0,32'h20080005, 0,32'hA5, 0,1);
    addVec("sto3", 1,0,32'h0,  1,1,32'h100,32'hDEADBEEF, 1,32'h12345678, 0,0,32'h100,32'hDEADBEEF, 0,32'h20080005, 1,32'hA5, 0,0);
    addVec("sto4", 1,0,32'h0,  1,1,32'h100,32'hDEADBEEF, 0,32'h0, 0,0,32'h100,32'hDEADBEEF, 0,32'h20080005, 0,32'hA5, 0,1);
    addVec("sto5", 1,0,32'h0,  0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h100,32'hDEADBEEF, 0,32'h20080005, 0,32'hA5, 0,0);
    addVec("mrs1", 1,1,32'h48, 0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h48, 32'hDEADBEEF, 0,32'h20080005, 0,32'hA5, 1,0);
    addVec("mrs2", 0,1,32'h48, 0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h0,  32'h0, 0,32'h0, 0,32'h0, 1,0);
    addVec("mrs3", 1,1,32'h48, 0,0,32'h0,  32'h0, 0,32'h0,        1,0,32'h48, 32'h0, 0,32'h0, 0,32'h0, 1,0);
    addVec("mrs4", 1,1,32'h48, 0,0,32'h0,  32'h0, 1,32'h22222222, 0,0,32'h48, 32'h0, 1,32'h22222222, 0,32'h0, 0,0);
    addVec("mrs5", 1,1,32'h48, 0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h48, 32'h0, 0,32'h22222222, 0,32'h0, 1,0);
    addVec("mrs6", 1,0,32'h0,  0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h48, 32'h0, 0,32'h22222222, 0,32'h0, 0,0);
    addVec("str1", 1,0,32'h0,  0,0,32'h0,  32'h0, 1,32'h33333333, 0,0,32'h48, 32'h0, 0,32'h22222222, 0,32'h0, 0,0);
    addVec("str2", 1,0,32'h0,  0,0,32'h0,  32'h0, 1,32'h33333333, 0,0,32'h48, 32'h0, 0,32'h22222222, 0,32'h0, 0,0);
    addVec("str3", 1,0,32'h0,  0,0,32'h0,  32'h0, 0,32'h0,        0,0,32'h48, 32'h0, 0,32'h22222222, 0,32'h0, 0,0);

    $display("[TB] directed table: %0d vectors", vecs.size());
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkVec(vecNames[i], vecs[i]);
    end

    // Both requesters held continuously, memory answering one cycle after
    // mreq rises: grants must alternate data, fetch, data, fetch.
    $display("[TB] continuous contention sequence");
    expOrder[0] = 32'h300; expOrder[1] = 32'h200;
    expOrder[2] = 32'h300; expOrder[3] = 32'h200;
    rst = 1; ireq = 1; iaddr = 32'h200; dreq = 1; dwe = 0; daddr = 32'h300;
    dwdata = 0; mready = 0; mrdata = 0;
    prevMreq = 0;
    for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
      @(posedge clk); #1;
      if (mreq && !prevMreq) order.push_back(maddr);
      mready   = mreq && prevMreq;
      mrdata   = $urandom;
      prevMreq = mreq;
    end
    checkOutput("rr.count", order.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr.grant%0d", i),
                  (i < order.size()) ? order[i] : 32'hFFFF_FFFF, expOrder[i]);
    end

    // Resynchronise DUT and model through reset, then run randomly.
    $display("[TB] randomized run against reference model");
    ireq = 0; dreq = 0; mready = 0; rst = 0;
    @(posedge clk); #1;
    rst = 1;
    modelReset();
    for (int i = 0; i < 256; i++) begin
      memArr[i]   = $urandom;
      modelMem[i] = memArr[i];
    end
    iFinish = 0; dFinish = 0; memPrev = 0; memAge = 0; memLat = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      checkOutput("rnd.mreq",   {31'd0, mreq},   {31'd0, eMreq});
      checkOutput("rnd.mwe",    {31'd0, mwe},    {31'd0, eMwe});
      checkOutput("rnd.maddr",  maddr,           eMaddr);
      checkOutput("rnd.mwdata", mwdata,          eMwdata);
      checkOutput("rnd.irdata", irdata,          eIrdata);
      checkOutput("rnd.drdata", drdata,          eDrdata);
      checkOutput("rnd.istall", {31'd0, istall}, {31'd0, ireq & ~eIdone});
      checkOutput("rnd.dstall", {31'd0, dstall}, {31'd0, dreq & ~eDdone});

      rst = ($urandom_range(0, 99) != 0);

      if (iFinish) begin
        iFinish = 0;
        ireq = $urandom_range(0, 1);
        if (ireq) iaddr = $urandom;
      end else if (ireq) begin
        if (eIdone) iFinish = 1;
        else if ($urandom_range(0, 31) == 0) ireq = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        ireq = 1; iaddr = $urandom;
      end

      if (dFinish) begin
        dFinish = 0;
        dreq = $urandom_range(0, 1);
        if (dreq) begin dwe = $urandom_range(0, 1); daddr = $urandom; dwdata = $urandom; end
      end else if (dreq) begin
        if (eDdone) dFinish = 1;
        else if ($urandom_range(0, 31) == 0) dreq = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        dreq = 1; dwe = $urandom_range(0, 1); daddr = $urandom; dwdata = $urandom;
      end

      // Behavioural memory: answers 1..3 cycles after mreq rises, and now
      // and then pulses mready while idle.
      if (mreq) begin
        if (!memPrev) begin
          memAge = 0;
          memLat = $urandom_range(1, 3);
        end else begin
          memAge++;
        end
        mready = rst && (memAge >= memLat);
      end else begin
        mready = ($urandom_range(0, 7) == 0);
      end
      memPrev = mreq && rst;
      mrdata  = mready ? memArr[maddr[9:2]] : $urandom;
      if (mready && mreq && mwe && rst) memArr[maddr[9:2]] = mwdata;

      modelStep();
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
